// File: rtl/sonar_seq_pkg.sv
// rtl/sonar_seq_pkg.sv - shared widths, timeout default and state encoding for the chirp burst sequencer
package sonar_seq_pkg;

    localparam int CNT_W_DEF      = 32;
    localparam int NP_W_DEF       = 16;
    localparam int TX_TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_TX_WAIT,
        S_TX,
        S_GUARD,
        S_LISTEN,
        S_PRI_WAIT
    } state_t;

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter that saturates at zero and flags expiry
module cycle_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/chirp_burst_sequencer.sv
// rtl/chirp_burst_sequencer.sv - fires a burst of chirps at a fixed PRI with guard and receive windows per pulse
module chirp_burst_sequencer
    import sonar_seq_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int NP_W       = NP_W_DEF,
    parameter int TX_TIMEOUT = TX_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [NP_W-1:0]  num_pulses,
    input  logic [CNT_W-1:0] step_delay,
    input  logic [CNT_W-1:0] guard_cycles,
    input  logic [CNT_W-1:0] listen_cycles,
    input  logic [CNT_W-1:0] pri_cycles,
    input  logic             chirp_valid,
    output logic             gen,
    output logic [CNT_W-1:0] gen_delay,
    output logic             tx_active,
    output logic             rx_gate,
    output logic [NP_W-1:0]  pulse_idx,
    output logic             busy,
    output logic             done,
    output logic             err_timeout
);

    state_t           state_q, state_d;
    logic [NP_W-1:0]  np_q, np_d, idx_q, idx_d;
    logic [CNT_W-1:0] delay_q, delay_d, guard_q, guard_d, listen_q, listen_d, pri_q, pri_d;
    logic             gen_q, gen_d, tx_q, tx_d, rx_q, rx_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             pri_load, win_load, pri_exp, win_exp;
    logic [CNT_W-1:0] pri_val, win_val;
    logic             last_pulse;

    function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] k);
        return (v > k) ? v - k : '0;
    endfunction

    // Two cycles of the interval are spent in PRI_WAIT->ARM->gen, so the timer is preloaded short by 2.
    cycle_timer #(.W(CNT_W)) u_pri_timer (
        .clk(clk), .rstn(rstn), .load(pri_load), .load_val(pri_val), .expired(pri_exp)
    );

    // Shared between the TX timeout and the guard/listen windows; they never overlap.
    cycle_timer #(.W(CNT_W)) u_win_timer (
        .clk(clk), .rstn(rstn), .load(win_load), .load_val(win_val), .expired(win_exp)
    );

    assign last_pulse = (idx_q == np_q - NP_W'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            np_q     <= '0;
            idx_q    <= '0;
            delay_q  <= '0;
            guard_q  <= '0;
            listen_q <= '0;
            pri_q    <= '0;
            gen_q    <= 1'b0;
            tx_q     <= 1'b0;
            rx_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            np_q     <= np_d;
            idx_q    <= idx_d;
            delay_q  <= delay_d;
            guard_q  <= guard_d;
            listen_q <= listen_d;
            pri_q    <= pri_d;
            gen_q    <= gen_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pri_load = 1'b0;
        pri_val  = sat_sub(pri_q, CNT_W'(2));
        win_load = 1'b0;
        win_val  = '0;
        case (state_q)
            S_IDLE: if (start) state_d = S_ARM;
            S_ARM: begin
                if (np_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_TX_WAIT;
                    pri_load = 1'b1;
                    win_load = 1'b1;
                    win_val  = CNT_W'(TX_TIMEOUT - 1);
                end
            end
            S_TX_WAIT: begin
                if (chirp_valid)  state_d = S_TX;
                else if (win_exp) state_d = S_IDLE;
            end
            S_TX: begin
                if (!chirp_valid) begin
                    if (guard_q != '0) begin
                        state_d  = S_GUARD;
                        win_load = 1'b1;
                        win_val  = sat_sub(guard_q, CNT_W'(1));
                    end else if (listen_q != '0) begin
                        state_d  = S_LISTEN;
                        win_load = 1'b1;
                        win_val  = sat_sub(listen_q, CNT_W'(1));
                    end else begin
                        state_d = S_PRI_WAIT;
                    end
                end
            end
            S_GUARD: begin
                if (win_exp) begin
                    if (listen_q != '0) begin
                        state_d  = S_LISTEN;
                        win_load = 1'b1;
                        win_val  = sat_sub(listen_q, CNT_W'(1));
                    end else begin
                        state_d = S_PRI_WAIT;
                    end
                end
            end
            S_LISTEN: if (win_exp) state_d = S_PRI_WAIT;
            S_PRI_WAIT: begin
                if (last_pulse)   state_d = S_IDLE;
                else if (pri_exp) state_d = S_ARM;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    // Outputs are registered from the next state so every port comes straight from a flop.
    always_comb begin
        np_d     = np_q;
        idx_d    = idx_q;
        delay_d  = delay_q;
        guard_d  = guard_q;
        listen_d = listen_q;
        pri_d    = pri_q;
        err_d    = err_q;
        if (state_q == S_IDLE && start) begin
            np_d     = num_pulses;
            delay_d  = step_delay;
            guard_d  = guard_cycles;
            listen_d = listen_cycles;
            pri_d    = pri_cycles;
            idx_d    = '0;
            err_d    = 1'b0;
        end
        if (state_q == S_PRI_WAIT && state_d == S_ARM) idx_d = idx_q + NP_W'(1);
        if (state_q == S_TX_WAIT && state_d == S_IDLE && !abort) err_d = 1'b1;
        gen_d  = (state_q == S_ARM) && (state_d == S_TX_WAIT);
        tx_d   = (state_d == S_TX_WAIT) || (state_d == S_TX);
        rx_d   = (state_d == S_LISTEN);
        busy_d = (state_d != S_IDLE);
        done_d = !abort && (((state_q == S_ARM) && (np_q == '0)) ||
                            ((state_q == S_PRI_WAIT) && last_pulse));
    end

    assign gen         = gen_q;
    assign gen_delay   = delay_q;
    assign tx_active   = tx_q;
    assign rx_gate     = rx_q;
    assign pulse_idx   = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_chirp_burst_sequencer.sv
// tb/tb_chirp_burst_sequencer.sv - scoreboard bench for chirp_burst_sequencer with a timing reference model
module tb_chirp_burst_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_pulses = '0;
    logic [31:0] step_delay = '0;
    logic [31:0] guard_cycles = '0;
    logic [31:0] listen_cycles = '0;
    logic [31:0] pri_cycles = '0;
    logic        chirp_valid = 1'b0;
    logic        gen, tx_active, rx_gate, busy, done, err_timeout;
    logic [31:0] gen_delay;
    logic [15:0] pulse_idx;

    chirp_burst_sequencer dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .num_pulses(num_pulses), .step_delay(step_delay), .guard_cycles(guard_cycles),
        .listen_cycles(listen_cycles), .pri_cycles(pri_cycles), .chirp_valid(chirp_valid),
        .gen(gen), .gen_delay(gen_delay), .tx_active(tx_active), .rx_gate(rx_gate),
        .pulse_idx(pulse_idx), .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    typedef struct { int cyc; int idx; int dly; } gen_t;
    typedef struct { int cyc; int len; } rx_t;

    gen_t exp_gen[$];
    rx_t  exp_rx[$];
    int   exp_done[$];
    int   exp_err[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int resp_d = 1;
    int resp_l = 10;
    bit resp_en = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Chirp generator stand-in: valid rises resp_d cycles after gen and stays up resp_l cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (gen && resp_en) begin
                repeat (resp_d) @(posedge clk);
                #1 chirp_valid = 1'b1;
                repeat (resp_l) @(posedge clk);
                #1 chirp_valid = 1'b0;
            end
        end
    end

    gen_t mg;
    rx_t  mr;
    int   m_int;
    int   rx_start = 0;
    bit   rx_prev = 1'b0;
    bit   err_prev = 1'b0;

    always @(negedge clk) begin
        if (rstn) begin
            if (gen) begin
                chk("gen_expected", exp_gen.size() > 0, 1);
                if (exp_gen.size() > 0) begin
                    mg = exp_gen.pop_front();
                    chk("gen_cycle", cyc, mg.cyc);
                    chk("gen_pulse_idx", pulse_idx, mg.idx);
                    chk("gen_delay", gen_delay, mg.dly);
                    chk("gen_tx_active", tx_active, 1);
                end
            end
            if (rx_gate && !rx_prev) rx_start = cyc;
            if (!rx_gate && rx_prev) begin
                chk("rx_expected", exp_rx.size() > 0, 1);
                if (exp_rx.size() > 0) begin
                    mr = exp_rx.pop_front();
                    chk("rx_start_cycle", rx_start, mr.cyc);
                    chk("rx_length", cyc - rx_start, mr.len);
                end
            end
            if (done) begin
                chk("done_expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) begin
                    m_int = exp_done.pop_front();
                    chk("done_cycle", cyc, m_int);
                    chk("done_busy_low", busy, 0);
                end
            end
            if (err_timeout && !err_prev) begin
                chk("err_expected", exp_err.size() > 0, 1);
                if (exp_err.size() > 0) begin
                    m_int = exp_err.pop_front();
                    chk("err_cycle", cyc, m_int);
                    chk("err_busy_low", busy, 0);
                end
            end
            rx_prev  = rx_gate;
            err_prev = err_timeout;
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("idle_within_budget", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("gen_queue_drained", exp_gen.size(), 0);
        chk("rx_queue_drained", exp_rx.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        chk("err_queue_drained", exp_err.size(), 0);
    endtask

    task automatic set_cfg(input int n, input int p, input int sd, input int g, input int lis);
        num_pulses    = 16'(n);
        pri_cycles    = 32'(p);
        step_delay    = 32'(sd);
        guard_cycles  = 32'(g);
        listen_cycles = 32'(lis);
    endtask

    task automatic scramble_cfg();
        num_pulses    = 16'($urandom);
        pri_cycles    = $urandom;
        step_delay    = $urandom;
        guard_cycles  = $urandom;
        listen_cycles = $urandom;
    endtask

    // Model: gen(i+1) = gen(i) + max(PRI, chirp + guard + listen + 3); chirp = resp latency + length.
    task automatic burst(input int n, input int p, input int sd, input int g, input int lis,
                         input int d, input int l, input bit ab);
        int s, gt, span;
        gen_t e;
        rx_t  r;
        resp_d = d;
        resp_l = l;
        resp_en = 1'b1;
        set_cfg(n, p, sd, g, lis);
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = ab;
        s = cyc;
        gt = s + 2;
        span = d + l + g + lis + 3;
        if (n == 0) exp_done.push_back(s + 2);
        for (int i = 0; i < n; i++) begin
            e.cyc = gt; e.idx = i; e.dly = sd;
            exp_gen.push_back(e);
            if (lis > 0) begin
                r.cyc = gt + d + l + 1 + g;
                r.len = lis;
                exp_rx.push_back(r);
            end
            if (i == n - 1) exp_done.push_back(gt + d + l + g + lis + 2);
            else gt += (p > span) ? p : span;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        scramble_cfg();
        chk("start_clears_err", err_timeout, 0);
        chk("busy_after_start", busy, 1);
        wait_idle();
    endtask

    task automatic wait_until(input int target);
        int k = 0;
        while (cyc < target && k < 20000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("reached_target_cycle", cyc >= target, 1);
    endtask

    initial begin
        int s, g0, r0;
        gen_t e;
        rx_t  r;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {gen, tx_active, rx_gate, busy, done, err_timeout, pulse_idx, gen_delay}, 0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        burst(3, 2000, 7, 10, 500, 2, 403, 1'b0);
        burst(3, 100, 5, 10, 500, 2, 403, 1'b0);
        burst(0, 300, 4, 2, 3, 1, 10, 1'b0);
        burst(1, 50, 9, 0, 0, 3, 15, 1'b1);

        // Chirp never arrives.
        resp_en = 1'b0;
        set_cfg(2, 400, 11, 4, 8);
        @(posedge clk);
        #1;
        start = 1'b1;
        s = cyc;
        e.cyc = s + 2; e.idx = 0; e.dly = 11;
        exp_gen.push_back(e);
        exp_err.push_back(s + 2 + 1024);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        chk("err_sticky", err_timeout, 1);
        resp_en = 1'b1;
        burst(1, 60, 2, 1, 1, 1, 5, 1'b0);

        // Abort during the listen window.
        set_cfg(2, 3000, 3, 5, 100);
        resp_d = 1;
        resp_l = 30;
        @(posedge clk);
        #1;
        start = 1'b1;
        s = cyc;
        g0 = s + 2;
        r0 = g0 + 1 + 30 + 1 + 5;
        e.cyc = g0; e.idx = 0; e.dly = 3;
        exp_gen.push_back(e);
        r.cyc = r0; r.len = 6;
        exp_rx.push_back(r);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_until(r0 + 5);
        chk("listen_before_abort", rx_gate, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_rx_low", rx_gate, 0);
        chk("abort_busy_low", busy, 0);
        wait_idle();

        // Asynchronous reset while the chirp is playing.
        set_cfg(1, 500, 13, 3, 20);
        resp_d = 2;
        resp_l = 100;
        @(posedge clk);
        #1;
        start = 1'b1;
        s = cyc;
        e.cyc = s + 2; e.idx = 0; e.dly = 13;
        exp_gen.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_until(s + 12);
        chk("tx_before_reset", tx_active, 1);
        #2 rstn = 1'b0;
        #1;
        chk("async_reset_outputs", {gen, tx_active, rx_gate, busy, done, err_timeout, pulse_idx, gen_delay}, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", busy, 0);
        repeat (120) @(posedge clk);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            burst($urandom_range(3, 1), $urandom_range(900, 20), $urandom_range(1000, 0),
                  $urandom_range(20, 0), $urandom_range(60, 0), $urandom_range(4, 1),
                  $urandom_range(150, 5), 1'($urandom_range(1, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
